usb_sfifo_loopback: RTL and testbench
=====================================

USB_SFIFO_LOOPBACK -- requirements
Module: usb_sfifo_loopback

Interface
REQ-001 Parameter PKT_WORDS, default 256, gives the packet length in 16-bit words (range 2..256).
REQ-002 Port USB_IFCLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port USB_RSTN, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port USB_DATA, inout, 16 bits: slave-FIFO data bus; the block drives it only in WR_SEL/WR, otherwise high-Z.
REQ-005 Port USB_ADDR, output, 2 bits: FIFO select; 2'b00 = EP2 OUT FIFO, 2'b10 = EP6 IN FIFO.
REQ-006 Port USB_SLRD, output, 1 bit: read strobe, active-low.
REQ-007 Port USB_SLWR, output, 1 bit: write strobe, active-low.
REQ-008 Port USB_SLOE, output, 1 bit: FIFO output enable, active-low.
REQ-009 Port USB_PKEND, output, 1 bit: packet-end commit, active-low.
REQ-010 Port USB_FLAGA, input, 1 bit: EP2 not-empty, 1 = data available.
REQ-011 Port USB_FLAGD, input, 1 bit: EP6 not-full, 1 = space available.
REQ-012 Port LED, output, 4 bits: status display.

Function
REQ-013 States SHALL be IDLE, RD_SEL, RD, WR_SEL, WR, PKEND, in that order, then back to IDLE.
REQ-014 IDLE: ADDR=00, all strobes high; when FLAGA=1, go to RD_SEL next cycle.
REQ-015 RD_SEL lasts one cycle: SLOE=0, ADDR=00, SLRD=1 (bus turnaround).
REQ-016 RD: SLOE=0, ADDR=00; SLRD = NOT FLAGA (combinational).
REQ-017 RD capture: on each edge with SLRD=0 and FLAGA=1, write USB_DATA into buf[rcnt] and increment rcnt.
REQ-018 RD with FLAGA=0: stall with no capture and no count change, for any number of cycles.
REQ-019 RD exit: the capture at rcnt=PKT_WORDS-1 SHALL go to WR_SEL; rcnt clears; SLRD is never low in the following cycle.
REQ-020 WR_SEL lasts one cycle: SLOE=1, ADDR=10, strobes high; the block begins driving USB_DATA=buf[0].
REQ-021 WR: USB_DATA=buf[wcnt]; SLWR = NOT FLAGD (combinational).
REQ-022 WR advance: each edge with SLWR=0 and FLAGD=1 increments wcnt.
REQ-023 WR with FLAGD=0: stall holding USB_DATA stable.
REQ-024 WR exit: the write at wcnt=PKT_WORDS-1 SHALL go to PKEND.
REQ-025 PKEND: USB_PKEND=0 for exactly one cycle with ADDR=10 when PKT_WORDS<256; when PKT_WORDS=256, PKEND stays high (auto-commit); then return to IDLE.
REQ-026 Counters rcnt/wcnt are 9 bits and never wrap past PKT_WORDS-1.
REQ-027 The buffer is written only in RD and read only in WR; no simultaneous access.
REQ-028 SLRD and SLWR SHALL never be low together; SLWR is never low while SLOE=0.
REQ-029 LED[0]=1 in RD_SEL/RD; LED[1]=1 in WR_SEL/WR/PKEND; LED[3:2] = completed-packet count mod 4, incremented on leaving PKEND.

Reset
REQ-030 USB_RSTN=0 SHALL immediately force: state IDLE, SLRD=SLWR=SLOE=PKEND=1, ADDR=00, USB_DATA high-Z, rcnt=wcnt=0, LED=0.
REQ-031 Reset mid-RD/WR SHALL abandon the partial packet with no PKEND; buffer contents need not clear.
REQ-032 After release, the first action is the IDLE FLAGA check.

Structure
REQ-033 Package usb_sfifo_pkg SHALL hold FIFO address constants (EP2=2'b00, EP6=2'b10) and the state encodings.
REQ-034 The buffer SHALL be sub-module usb_pkt_buf: 256x16, one write port, asynchronous read.

Verification
REQ-035 FX2 model with 256 words 0..255 in EP2, FLAGA/FLAGD=1 -> EP6 receives 0..255 in order, PKEND never low, LED[3:2]=01.
REQ-036 PKT_WORDS=16, data 16'hA000+i -> 16 words out, one PKEND low pulse after the 16th SLWR, then IDLE.
REQ-037 FLAGA dropped for 5 cycles at word 100 -> SLRD high for exactly those cycles, no duplicate or lost word.
REQ-038 FLAGD dropped for 3 cycles at word 50 -> USB_DATA holds word 50, SLWR high, then resumes.
REQ-039 USB_RSTN pulsed low at RD word 40 -> outputs take reset values within the same cycle; the next packet starts at rcnt=0 and completes correctly.
REQ-040 All scenarios: assert SLRD/SLWR never both low, and USB_DATA never driven while SLOE=0.

Source files
------------

// File: rtl/usb_sfifo_pkg.sv
// Shared constants for the FX2 slave-FIFO loopback: FIFO addresses, buffer geometry, FSM states.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package usb_sfifo_pkg;

    // FIFOADR values presented to the FX2
    localparam logic [1:0] FIFO_EP2 = 2'b00;   // host->device OUT endpoint
    localparam logic [1:0] FIFO_EP6 = 2'b10;   // device->host IN endpoint

    localparam int BUF_DEPTH = 256;
    localparam int DATA_W    = 16;

    // Declaration order is the packet walk order; PKEND wraps back to IDLE
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_SEL,
        ST_RD,
        ST_WR_SEL,
        ST_WR,
        ST_PKEND
    } state_t;

endpackage

// File: rtl/usb_pkt_buf.sv
// One-packet store: 256x16, single synchronous write port, asynchronous read port.
// Latency: write lands on the clock edge; read data follows raddr combinationally.
// Backpressure: none; the caller guarantees write and read phases never overlap.
// Ports: clk; we/waddr/wdata write port; raddr/rdata read port.
module usb_pkt_buf
    import usb_sfifo_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [7:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [7:0]        raddr,
    output logic [DATA_W-1:0] rdata
);

    // No reset: a packet abandoned by reset is simply overwritten by the next one
    logic [DATA_W-1:0] mem_q [BUF_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/usb_sfifo_loopback.sv
// FX2 slave-FIFO loopback: read one PKT_WORDS packet from EP2, write it back to EP6, commit it.
// Latency: one turnaround cycle before each phase, one word per cycle, one PKEND cycle at the end.
// Backpressure: FLAGA low stalls reads, FLAGD low stalls writes; strobes follow the flags combinationally.
// Ports: USB_IFCLK/USB_RSTN clock and async active-low reset; USB_DATA bidirectional FIFO bus;
//        USB_ADDR/SLRD/SLWR/SLOE/PKEND FIFO controls; USB_FLAGA EP2 not-empty, USB_FLAGD EP6 not-full;
//        LED = {packet count mod 4, write phase, read phase}.
module usb_sfifo_loopback
    import usb_sfifo_pkg::*;
#(
    parameter int PKT_WORDS = 256
) (
    input  logic        USB_IFCLK,
    input  logic        USB_RSTN,
    inout  wire  [15:0] USB_DATA,
    output logic [1:0]  USB_ADDR,
    output logic        USB_SLRD,
    output logic        USB_SLWR,
    output logic        USB_SLOE,
    output logic        USB_PKEND,
    input  logic        USB_FLAGA,
    input  logic        USB_FLAGD,
    output logic [3:0]  LED
);

    localparam logic [8:0] LAST_IDX  = 9'(PKT_WORDS - 1);
    // A full 256-word packet is committed by the FX2 itself; only short packets need PKEND
    localparam logic       SHORT_PKT = (PKT_WORDS < 256);

    state_t      state_q, state_d;
    logic [8:0]  rcnt_q, rcnt_d;
    logic [8:0]  wcnt_q, wcnt_d;
    logic [1:0]  pkt_cnt_q, pkt_cnt_d;

    logic        buf_we;
    logic        data_oe;
    logic [15:0] buf_rdata;

    usb_pkt_buf u_buf (
        .clk   (USB_IFCLK),
        .we    (buf_we),
        .waddr (rcnt_q[7:0]),
        .wdata (USB_DATA),
        .raddr (wcnt_q[7:0]),
        .rdata (buf_rdata)
    );

    always_comb begin
        state_d   = state_q;
        rcnt_d    = rcnt_q;
        wcnt_d    = wcnt_q;
        pkt_cnt_d = pkt_cnt_q;
        USB_ADDR  = FIFO_EP2;
        USB_SLRD  = 1'b1;
        USB_SLWR  = 1'b1;
        USB_SLOE  = 1'b1;
        USB_PKEND = 1'b1;
        data_oe   = 1'b0;
        buf_we    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (USB_FLAGA) begin
                    state_d = ST_RD_SEL;
                end
            end
            ST_RD_SEL: begin
                // FX2 gets one cycle to turn the bus around before the first strobe
                USB_SLOE = 1'b0;
                state_d  = ST_RD;
            end
            ST_RD: begin
                USB_SLOE = 1'b0;
                USB_SLRD = ~USB_FLAGA;
                if (USB_FLAGA) begin
                    buf_we = 1'b1;
                    if (rcnt_q == LAST_IDX) begin
                        rcnt_d  = '0;
                        state_d = ST_WR_SEL;
                    end else begin
                        rcnt_d = rcnt_q + 9'd1;
                    end
                end
            end
            ST_WR_SEL: begin
                // FX2 has released the bus (SLOE high); present word 0 before the first strobe
                USB_ADDR = FIFO_EP6;
                data_oe  = 1'b1;
                state_d  = ST_WR;
            end
            ST_WR: begin
                USB_ADDR = FIFO_EP6;
                data_oe  = 1'b1;
                USB_SLWR = ~USB_FLAGD;
                if (USB_FLAGD) begin
                    if (wcnt_q == LAST_IDX) begin
                        wcnt_d  = '0;
                        state_d = ST_PKEND;
                    end else begin
                        wcnt_d = wcnt_q + 9'd1;
                    end
                end
            end
            ST_PKEND: begin
                USB_ADDR  = FIFO_EP6;
                USB_PKEND = ~SHORT_PKT;
                pkt_cnt_d = pkt_cnt_q + 2'd1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge USB_IFCLK or negedge USB_RSTN) begin
        if (!USB_RSTN) begin
            state_q   <= ST_IDLE;
            rcnt_q    <= '0;
            wcnt_q    <= '0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            wcnt_q    <= wcnt_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign USB_DATA = data_oe ? buf_rdata : 16'hzzzz;

    assign LED = {pkt_cnt_q,
                  (state_q == ST_WR_SEL) || (state_q == ST_WR) || (state_q == ST_PKEND),
                  (state_q == ST_RD_SEL) || (state_q == ST_RD)};

endmodule

// File: tb/tb_usb_sfifo_loopback.sv
// Directed bench: FX2 slave-FIFO model around a 256-word and a 16-word loopback instance.
// Latency: n/a (testbench).
// Backpressure: flags are driven by the stimulus sequence to stall each phase.
module tb_usb_sfifo_loopback;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;
    int   vectors     = 0;
    int   miscompares = 0;
    int   viol        = 0;

    // ---------------- DUT A: 256-word packets ----------------
    wire  [15:0] data_a;
    logic [1:0]  addr_a;
    logic        slrd_a, slwr_a, sloe_a, pkend_a;
    logic        flaga_a, flagd_a;
    logic [3:0]  led_a;
    logic [15:0] src_a [0:1023];
    int          rd_ptr_a = 0;
    int          rd_lim_a = 0;
    logic        flaga_en_a = 1'b0;
    logic [15:0] snk_a [$];
    int          pk_a = 0;

    assign flaga_a = flaga_en_a && (rd_ptr_a < rd_lim_a);
    assign data_a  = (!sloe_a && addr_a == 2'b00) ? src_a[rd_ptr_a[9:0]] : 16'hzzzz;

    usb_sfifo_loopback #(.PKT_WORDS(256)) dut_a (
        .USB_IFCLK (clk),
        .USB_RSTN  (rstn),
        .USB_DATA  (data_a),
        .USB_ADDR  (addr_a),
        .USB_SLRD  (slrd_a),
        .USB_SLWR  (slwr_a),
        .USB_SLOE  (sloe_a),
        .USB_PKEND (pkend_a),
        .USB_FLAGA (flaga_a),
        .USB_FLAGD (flagd_a),
        .LED       (led_a)
    );

    // ---------------- DUT B: 16-word packets ----------------
    wire  [15:0] data_b;
    logic [1:0]  addr_b;
    logic        slrd_b, slwr_b, sloe_b, pkend_b;
    logic        flaga_b, flagd_b;
    logic [3:0]  led_b;
    logic [15:0] src_b [0:255];
    int          rd_ptr_b = 0;
    int          rd_lim_b = 0;
    logic        flaga_en_b = 1'b0;
    logic [15:0] snk_b [$];
    int          pk_b = 0;

    assign flaga_b = flaga_en_b && (rd_ptr_b < rd_lim_b);
    assign data_b  = (!sloe_b && addr_b == 2'b00) ? src_b[rd_ptr_b[7:0]] : 16'hzzzz;

    usb_sfifo_loopback #(.PKT_WORDS(16)) dut_b (
        .USB_IFCLK (clk),
        .USB_RSTN  (rstn),
        .USB_DATA  (data_b),
        .USB_ADDR  (addr_b),
        .USB_SLRD  (slrd_b),
        .USB_SLWR  (slwr_b),
        .USB_SLOE  (sloe_b),
        .USB_PKEND (pkend_b),
        .USB_FLAGA (flaga_b),
        .USB_FLAGD (flagd_b),
        .LED       (led_b)
    );

    // FX2 side: pop EP2 on a read strobe, push EP6 on a write strobe
    always @(posedge clk) begin
        if (!slrd_a && flaga_a) rd_ptr_a <= rd_ptr_a + 1;
        if (!slwr_a && flagd_a) snk_a.push_back(data_a);
        if (!slrd_b && flaga_b) rd_ptr_b <= rd_ptr_b + 1;
        if (!slwr_b && flagd_b) snk_b.push_back(data_b);
    end

    // Bus-protocol invariants, sampled mid-cycle
    always @(negedge clk) begin
        if (!pkend_a) pk_a++;
        if (!pkend_b) pk_b++;
        if (!slrd_a && !slwr_a) viol++;
        if (!slwr_a && !sloe_a) viol++;
        if (!sloe_a && data_a !== src_a[rd_ptr_a[9:0]]) viol++;
        if (!slrd_b && !slwr_b) viol++;
        if (!slwr_b && !sloe_b) viol++;
        if (!sloe_b && data_b !== src_b[rd_ptr_b[7:0]]) viol++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ptr_a(input int target);
        for (int t = 0; t < 3000 && rd_ptr_a < target; t++) @(negedge clk);
        check("wait_rd_ptr", rd_ptr_a, target);
    endtask

    task automatic wait_snk_a(input int target);
        for (int t = 0; t < 3000 && snk_a.size() < target; t++) @(negedge clk);
        check("wait_snk", snk_a.size(), target);
    endtask

    initial begin
        int p, base, err, pk0;

        rstn    = 1'b0;
        flagd_a = 1'b0;
        flagd_b = 1'b0;
        repeat (2) @(negedge clk);

        // reset values
        check("rst_slrd",  slrd_a,  1);
        check("rst_slwr",  slwr_a,  1);
        check("rst_sloe",  sloe_a,  1);
        check("rst_pkend", pkend_a, 1);
        check("rst_addr",  addr_a,  2'b00);
        check("rst_led",   led_a,   4'b0000);

        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_sloe", sloe_a, 1);
        check("idle_led",  led_a,  4'b0000);

        // ---- packet 1: 0..255, no stalls ----
        p = rd_ptr_a; base = snk_a.size(); pk0 = pk_a;
        for (int i = 0; i < 256; i++) src_a[p + i] = 16'(i);
        rd_lim_a   = p + 256;
        flaga_en_a = 1'b1;
        flagd_a    = 1'b1;
        @(negedge clk);
        check("rdsel_sloe", sloe_a, 0);
        check("rdsel_slrd", slrd_a, 1);
        check("rdsel_led",  led_a,  4'b0001);
        wait_ptr_a(p + 256);
        check("wrsel_addr", addr_a, 2'b10);
        check("wrsel_sloe", sloe_a, 1);
        check("wrsel_slrd", slrd_a, 1);
        check("wrsel_slwr", slwr_a, 1);
        check("wrsel_data", data_a, 16'h0000);
        wait_snk_a(base + 256);
        check("p1_auto_commit", pkend_a, 1);
        check("p1_pkend_led",   led_a,   4'b0010);
        @(negedge clk);
        check("p1_idle_led", led_a, 4'b0100);
        err = 0;
        for (int i = 0; i < 256; i++) if (snk_a[base + i] !== 16'(i)) err++;
        check("p1_data", err, 0);
        check("p1_no_pkend", pk_a - pk0, 0);

        // ---- packet 2: FLAGA stall at word 100, FLAGD stall at word 50 ----
        p = rd_ptr_a; base = snk_a.size();
        for (int i = 0; i < 256; i++) src_a[p + i] = 16'(16'h8000 + 3 * i);
        rd_lim_a = p + 256;
        wait_ptr_a(p + 100);
        flaga_en_a = 1'b0;
        repeat (5) begin
            #1 check("rd_stall_slrd", slrd_a, 1);
            @(negedge clk);
        end
        check("rd_stall_ptr", rd_ptr_a, p + 100);
        check("rd_stall_led", led_a, 4'b0101);
        flaga_en_a = 1'b1;
        #1 check("rd_resume_slrd", slrd_a, 0);
        wait_snk_a(base + 50);
        flagd_a = 1'b0;
        repeat (3) begin
            #1 check("wr_stall_slwr", slwr_a, 1);
            check("wr_stall_data", data_a, 16'h8000 + 16'd150);
            @(negedge clk);
        end
        check("wr_stall_cnt", snk_a.size(), base + 50);
        flagd_a = 1'b1;
        #1 check("wr_resume_slwr", slwr_a, 0);
        wait_snk_a(base + 256);
        @(negedge clk);
        check("p2_idle_led", led_a, 4'b1000);
        err = 0;
        for (int i = 0; i < 256; i++) if (snk_a[base + i] !== 16'(16'h8000 + 3 * i)) err++;
        check("p2_data", err, 0);

        // ---- packet 3: reset at read word 40 ----
        p = rd_ptr_a; base = snk_a.size(); pk0 = pk_a;
        for (int i = 0; i < 256; i++) src_a[p + i] = 16'(16'h1111 + i);
        rd_lim_a = p + 256;
        wait_ptr_a(p + 40);
        rstn = 1'b0;
        #1;
        check("mid_rst_sloe",  sloe_a,  1);
        check("mid_rst_slrd",  slrd_a,  1);
        check("mid_rst_slwr",  slwr_a,  1);
        check("mid_rst_pkend", pkend_a, 1);
        check("mid_rst_addr",  addr_a,  2'b00);
        check("mid_rst_led",   led_a,   4'b0000);
        flaga_en_a = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check("abandon_no_pkend", pk_a - pk0, 0);
        check("abandon_no_write", snk_a.size(), base);

        // ---- packet 4: clean packet after reset ----
        p = rd_ptr_a; base = snk_a.size();
        for (int i = 0; i < 256; i++) src_a[p + i] = 16'(16'hC000 + i);
        rd_lim_a   = p + 256;
        flaga_en_a = 1'b1;
        wait_snk_a(base + 256);
        @(negedge clk);
        check("p4_led", led_a, 4'b0100);
        check("p4_first_word", snk_a[base], 16'hC000);
        err = 0;
        for (int i = 0; i < 256; i++) if (snk_a[base + i] !== 16'(16'hC000 + i)) err++;
        check("p4_data", err, 0);

        // ---- DUT B: 16-word packet with explicit PKEND ----
        pk0 = pk_b;
        for (int i = 0; i < 16; i++) src_b[i] = 16'(16'hA000 + i);
        rd_lim_b   = 16;
        flaga_en_b = 1'b1;
        flagd_b    = 1'b1;
        for (int t = 0; t < 500 && pkend_b !== 1'b0; t++) @(negedge clk);
        check("b_pkend_low",   pkend_b, 0);
        check("b_pkend_after", snk_b.size(), 16);
        check("b_pkend_addr",  addr_b, 2'b10);
        @(negedge clk);
        check("b_pkend_one",   pkend_b, 1);
        check("b_idle_led",    led_b, 4'b0100);
        check("b_pkend_count", pk_b - pk0, 1);
        err = 0;
        for (int i = 0; i < 16; i++) if (snk_b[i] !== 16'(16'hA000 + i)) err++;
        check("b_data", err, 0);

        check("bus_invariants", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
